irrigation_sequencer: RTL and testbench

//  Downstream stage of the irrigation combinational decoder. It consumes the request levels Ve, Bs, Vs and Al
//  and drives the physical actuators. It adds a minimum sprinkler/drip run time, a fill-valve watchdog,
//  and a latched alarm that needs an operator acknowledge.

---
 rtl/irrigation_sequencer.sv | 113 +++++++++++
 tb/tb_irrigation_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/irrigation_sequencer.sv
// Actuator sequencer behind the irrigation decoder: minimum run time, fill watchdog, latched alarm.
// Inputs are registered once; outputs are registered from the next state (two-edge input-to-output latency).
module irrigation_sequencer #(
  parameter int TICK_DIV     = 10,
  parameter int MIN_ON       = 30,
  parameter int FILL_TIMEOUT = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Ve,
  input  logic       Bs,
  input  logic       Vs,
  input  logic       Al,
  input  logic       alarm_ack,
  output logic       valve_in,
  output logic       pump,
  output logic       drip,
  output logic       alarm,
  output logic       fault_fill,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SPRINKLE = 2'b01,
    DRIP     = 2'b10,
    ALARM    = 2'b11
  } state_t;

  localparam int RUN_CYC = MIN_ON * TICK_DIV;
  localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW      = $clog2(RUN_CYC + 1);
  localparam int FW      = $clog2(FILL_TIMEOUT + 1);

  logic          Ve_r, Bs_r, Vs_r, Al_r, alarm_ack_r;
  logic [PW-1:0] presc;
  logic [RW-1:0] run_cnt;
  logic [FW-1:0] fill_cnt;
  state_t        cur_state, nxt_state;
  logic          tick, run_done, fill_hit, fill_fault;

  assign state = cur_state;

  always_comb begin
    tick       = (presc == PW'(TICK_DIV - 1));
    // run_cnt holds cycles spent in the state minus one, so this edge completes the minimum run
    run_done   = (run_cnt >= RW'(RUN_CYC - 1));
    fill_hit   = valve_in && tick && (fill_cnt == FW'(FILL_TIMEOUT - 1));
    fill_fault = fault_fill || fill_hit;
    nxt_state  = cur_state;
    case (cur_state)
      IDLE: begin
        if (Al_r || fill_fault)  nxt_state = ALARM;
        else if (Bs_r)           nxt_state = SPRINKLE;
        else if (Vs_r)           nxt_state = DRIP;
      end
      SPRINKLE: begin
        if (Al_r || fill_fault)      nxt_state = ALARM;
        else if (run_done && !Bs_r)  nxt_state = Vs_r ? DRIP : IDLE;
      end
      DRIP: begin
        if (Al_r || fill_fault)      nxt_state = ALARM;
        else if (run_done && !Vs_r)  nxt_state = Bs_r ? SPRINKLE : IDLE;
      end
      ALARM: begin
        if (!Al_r && alarm_ack_r)    nxt_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Ve_r        <= 1'b0;
      Bs_r        <= 1'b0;
      Vs_r        <= 1'b0;
      Al_r        <= 1'b0;
      alarm_ack_r <= 1'b0;
      presc       <= '0;
      run_cnt     <= '0;
      fill_cnt    <= '0;
      cur_state   <= IDLE;
      valve_in    <= 1'b0;
      pump        <= 1'b0;
      drip        <= 1'b0;
      alarm       <= 1'b0;
      fault_fill  <= 1'b0;
    end else begin
      Ve_r        <= Ve;
      Bs_r        <= Bs;
      Vs_r        <= Vs;
      Al_r        <= Al;
      alarm_ack_r <= alarm_ack;
      presc       <= tick ? '0 : presc + 1'b1;
      cur_state   <= nxt_state;

      if (nxt_state != cur_state) run_cnt <= '0;
      else if (!run_done)         run_cnt <= run_cnt + 1'b1;

      valve_in <= Ve_r && (nxt_state != ALARM);
      pump     <= (nxt_state == SPRINKLE);
      drip     <= (nxt_state == DRIP);
      alarm    <= (nxt_state == ALARM);

      // Saturating; valve_in is forced low in ALARM, so a fault always clears the count afterwards
      if (!valve_in)                                   fill_cnt <= '0;
      else if (tick && fill_cnt != FW'(FILL_TIMEOUT)) fill_cnt <= fill_cnt + 1'b1;

      if (cur_state == ALARM && nxt_state == IDLE) fault_fill <= 1'b0;
      else if (fill_hit)                           fault_fill <= 1'b1;
    end
  end

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Bench for irrigation_sequencer with TICK_DIV=4, MIN_ON=3, FILL_TIMEOUT=5 (12-cycle minimum run).
module tb_irrigation_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       Ve, Bs, Vs, Al, alarm_ack;
  logic       valve_in, pump, drip, alarm, fault_fill;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  irrigation_sequencer #(.TICK_DIV(4), .MIN_ON(3), .FILL_TIMEOUT(5)) dut (
    .clk(clk), .reset(reset), .Ve(Ve), .Bs(Bs), .Vs(Vs), .Al(Al), .alarm_ack(alarm_ack),
    .valve_in(valve_in), .pump(pump), .drip(drip), .alarm(alarm),
    .fault_fill(fault_fill), .state(state)
  );

  always #5 clk = ~clk;

  // Expected output vector: {valve_in, pump, drip, alarm, fault_fill, state[1:0]}
  typedef struct {
    logic       ve, bs, vs, al, ack;
    int         hold;
    logic [6:0] exp;
  } vec_t;

  vec_t       tbl[15];
  logic [6:0] sb_q[$];

  function automatic vec_t mk(logic ve, logic bs, logic vs, logic al, logic ack, int hold, logic [6:0] exp);
    vec_t v;
    v.ve = ve; v.bs = bs; v.vs = vs; v.al = al; v.ack = ack; v.hold = hold; v.exp = exp;
    return v;
  endfunction

  function automatic logic [6:0] outs();
    return {valve_in, pump, drip, alarm, fault_fill, state};
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(logic ve, logic bs, logic vs, logic al, logic ack);
    Ve = ve; Bs = bs; Vs = vs; Al = al; alarm_ack = ack;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    step(2);
    chk("reset_outputs", int'(outs()), 0);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    logic [6:0] got, want;

    reset = 1'b1;
    drive(0, 0, 0, 0, 0);

    // Sequential vectors: each row's inputs are held for 'hold' cycles, then outputs compared
    tbl[0]  = mk(0, 0, 0, 0, 0,  2, 7'b00000_00);
    tbl[1]  = mk(1, 0, 0, 0, 0,  2, 7'b10000_00);
    tbl[2]  = mk(0, 0, 0, 0, 0,  2, 7'b00000_00);
    tbl[3]  = mk(0, 1, 0, 0, 0,  2, 7'b01000_01);
    tbl[4]  = mk(0, 0, 0, 0, 0,  5, 7'b01000_01);
    tbl[5]  = mk(0, 0, 0, 0, 0,  7, 7'b00000_00);
    tbl[6]  = mk(0, 0, 1, 0, 0,  2, 7'b00100_10);
    tbl[7]  = mk(1, 0, 0, 0, 0,  2, 7'b10100_10);
    tbl[8]  = mk(0, 0, 0, 0, 0, 12, 7'b00000_00);
    tbl[9]  = mk(0, 1, 1, 0, 0,  2, 7'b01000_01);
    tbl[10] = mk(0, 0, 1, 0, 0, 12, 7'b00100_10);
    tbl[11] = mk(0, 0, 1, 1, 0,  2, 7'b00010_11);
    tbl[12] = mk(0, 0, 0, 1, 1,  3, 7'b00010_11);
    tbl[13] = mk(0, 0, 0, 0, 1,  2, 7'b00000_00);
    tbl[14] = mk(0, 0, 0, 0, 0,  2, 7'b00000_00);

    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].ve, tbl[i].bs, tbl[i].vs, tbl[i].al, tbl[i].ack);
      sb_q.push_back(tbl[i].exp);
      step(tbl[i].hold);
      want = sb_q.pop_front();
      got  = outs();
      chk($sformatf("vec%0d", i), int'(got), int'(want));
    end

    // Two-cycle Bs pulse gives exactly one minimum run of pump
    do_reset();
    drive(0, 1, 0, 0, 0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 2) Bs = 1'b0;
      step(1);
      if (pump) n++;
    end
    chk("pump_width", n, 12);
    chk("pump_end_idle", int'(state), 0);

    // Long sprinkle handing over to drip on one edge
    do_reset();
    drive(0, 1, 0, 0, 0);
    step(20);
    drive(0, 0, 1, 0, 0);
    n = 0;
    while (pump && n < 10) begin step(1); n++; end
    chk("handover_pump_off", int'(pump), 0);
    chk("handover_latency", n, 2);
    chk("handover_drip_on", int'(drip), 1);
    chk("handover_state", int'(state), 2);
    drive(0, 0, 0, 0, 0);

    // Fill watchdog
    do_reset();
    drive(1, 0, 0, 0, 0);
    n = 0;
    while (!valve_in && n < 10) begin step(1); n++; end
    chk("fill_valve_latency", n, 2);
    n = 0;
    while (!fault_fill && n < 40) begin step(1); n++; end
    n_checks++;
    if (n < 17 || n > 20) begin
      n_fail++;
      $display("FAIL fill_timeout: fault after %0d cycles, expected 17..20", n);
    end
    chk("fill_alarm_state", int'(state), 3);
    chk("fill_valve_closed", int'(valve_in), 0);
    chk("fill_alarm_on", int'(alarm), 1);
    step(3);
    chk("fill_fault_sticky", int'(fault_fill), 1);
    drive(0, 0, 0, 0, 1);
    step(2);
    chk("fill_ack_state", int'(state), 0);
    chk("fill_ack_clear", int'(fault_fill), 0);
    drive(0, 0, 0, 0, 0);

    // Alarm during sprinkle, ack ignored while Al is high
    do_reset();
    drive(0, 1, 0, 0, 0);
    step(5);
    Al = 1'b1;
    step(1);
    chk("al_pump_still_on", int'(pump), 1);
    step(1);
    chk("al_pump_off", int'(pump), 0);
    chk("al_alarm_on", int'(alarm), 1);
    alarm_ack = 1'b1;
    step(4);
    chk("al_ack_ignored", int'(state), 3);
    Al = 1'b0;
    step(2);
    chk("al_ack_exit", int'(state), 0);
    drive(0, 0, 0, 0, 0);

    // Asynchronous reset mid-cycle during drip
    do_reset();
    drive(1, 0, 1, 0, 0);
    step(3);
    chk("drip_before_reset", int'(drip), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", int'(outs()), 0);
    step(1);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
